// File: rtl/gb_dma_pkg.sv
// Shared definitions for the OAM DMA path: state encoding, memory-map constants
// and the echo-RAM source-page fold.
package gb_dma_pkg;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_START,
    DMA_READ,
    DMA_WRITE
  } dma_state_t;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam int          OAM_LEN      = 160;
  localparam logic [15:0] HRAM_LO      = 16'hFF80;
  localparam logic [15:0] HRAM_HI      = 16'hFFFE;

  // Pages E0..FF alias work RAM at C0..DF.
  function automatic logic [7:0] echo_fold(input logic [7:0] page);
    return (page >= 8'hE0) ? page - 8'h20 : page;
  endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA engine: on a DMA register write, copies XFER_LEN bytes from {page,8'h00}
// to DEST_BASE over the shared memory bus, one read/write pair per byte.
//
// Bus handshake: bus_req is high in READ and WRITE; a strobe (mem_rd or mem_wr)
// is issued only in a cycle where bus_gnt is high, and the FSM advances only then.
module oam_dma_engine
  import gb_dma_pkg::*;
#(
  parameter int          XFER_LEN    = OAM_LEN,
  parameter logic [15:0] DEST_BASE   = OAM_BASE,
  parameter int          START_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dma_wr,
  input  logic [7:0]  dma_page,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  mem_wdata,
  output logic        busy,
  output logic        cpu_hram_only,
  output logic        done
);

  localparam logic [7:0] LAST_IDX  = 8'(XFER_LEN - 1);
  localparam logic [1:0] DLY_INIT  = 2'(START_DELAY);

  dma_state_t  state;
  logic [7:0]  src_hi;
  logic [7:0]  idx;
  logic [1:0]  dly;
  logic [7:0]  latch;
  logic        rd_pend;
  logic [15:0] addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= DMA_IDLE;
      src_hi  <= 8'h00;
      idx     <= 8'h00;
      dly     <= 2'd0;
      latch   <= 8'h00;
      rd_pend <= 1'b0;
      addr_q  <= 16'h0000;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (mem_rd || mem_wr) addr_q <= mem_addr;
      // A register write restarts from any state and suppresses the pending done.
      if (dma_wr) begin
        src_hi  <= echo_fold(dma_page);
        idx     <= 8'h00;
        dly     <= DLY_INIT;
        rd_pend <= 1'b0;
        state   <= (START_DELAY == 0) ? DMA_READ : DMA_START;
      end else begin
        case (state)
          DMA_START: begin
            if (dly <= 2'd1) state <= DMA_READ;
            else             dly   <= dly - 2'd1;
          end
          DMA_READ: begin
            if (bus_gnt) begin
              rd_pend <= 1'b1;
              state   <= DMA_WRITE;
            end
          end
          DMA_WRITE: begin
            // Read data is only valid in the cycle right after the granted read.
            if (rd_pend) begin
              latch   <= mem_rdata;
              rd_pend <= 1'b0;
            end
            if (bus_gnt) begin
              if (idx == LAST_IDX) begin
                state <= DMA_IDLE;
                done  <= 1'b1;
              end else begin
                idx   <= idx + 8'd1;
                state <= DMA_READ;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus_req       = (state == DMA_READ) || (state == DMA_WRITE);
    mem_rd        = (state == DMA_READ) && bus_gnt;
    mem_wr        = (state == DMA_WRITE) && bus_gnt;
    mem_wdata     = rd_pend ? mem_rdata : latch;
    mem_addr      = addr_q;
    if (mem_rd)      mem_addr = {src_hi, idx};
    else if (mem_wr) mem_addr = DEST_BASE + {8'h00, idx};
    busy          = (state != DMA_IDLE);
    cpu_hram_only = busy;
  end

endmodule

// File: tb/tb_oam_dma_engine.sv
// Directed bench for oam_dma_engine: full transfers, echo fold, grant stalls,
// retrigger, mid-transfer reset and retrigger on the final write.
module tb_oam_dma_engine;

  logic        clk;
  logic        rst;
  logic        dma_wr;
  logic [7:0]  dma_page;
  logic        bus_req;
  logic        bus_gnt;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_rdata;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        cpu_hram_only;
  logic        done;

  oam_dma_engine dut (
    .clk(clk), .rst(rst), .dma_wr(dma_wr), .dma_page(dma_page),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
    .mem_wdata(mem_wdata), .busy(busy), .cpu_hram_only(cpu_hram_only),
    .done(done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: data for addr A is A[7:0]^5A, one cycle after mem_rd.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem_addr[7:0] ^ 8'h5A;
    else        mem_rdata <= 8'hEE;
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  int wr_count = 0;
  int rd_count = 0;
  int done_count = 0;
  int t0 = 0;
  logic [15:0] exp_rd_q[$];
  logic [23:0] exp_wr_q[$];
  logic [15:0] rd_e;
  logic [23:0] wr_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("rd_wr_excl", 32'(mem_rd & mem_wr), 32'd0);
    check("strobe_needs_gnt", 32'((mem_rd | mem_wr) & ~bus_gnt), 32'd0);
    check("hram_eq_busy", 32'(cpu_hram_only), 32'(busy));
    check("req_only_busy", 32'(bus_req & ~busy), 32'd0);
    if (mem_rd) begin
      rd_count++;
      check("rd_expected", 32'(exp_rd_q.size() != 0), 32'd1);
      if (exp_rd_q.size() != 0) begin
        rd_e = exp_rd_q.pop_front();
        check("rd_addr", 32'(mem_addr), 32'(rd_e));
      end
    end
    if (mem_wr) begin
      wr_count++;
      check("wr_expected", 32'(exp_wr_q.size() != 0), 32'd1);
      if (exp_wr_q.size() != 0) begin
        wr_e = exp_wr_q.pop_front();
        check("wr_addr_data", 32'({mem_addr, mem_wdata}), 32'(wr_e));
      end
    end
    if (done) done_count++;
  end

  // ---------------- driver tasks ----------------
  task automatic load_expect(input logic [7:0] src);
    exp_rd_q.delete();
    exp_wr_q.delete();
    for (int i = 0; i < 160; i++) begin
      logic [7:0] b;
      b = 8'(i);
      exp_rd_q.push_back({src, b});
      exp_wr_q.push_back({16'hFE00 + {8'h00, b}, b ^ 8'h5A});
    end
  endtask

  // Ends on the negedge of the first cycle after dma_wr was sampled.
  task automatic pulse_dma(input logic [7:0] page);
    @(negedge clk);
    dma_wr   = 1'b1;
    dma_page = page;
    @(negedge clk);
    dma_wr   = 1'b0;
    t0       = cyc;
  endtask

  task automatic begin_run(input logic [7:0] page, input logic [7:0] src);
    done_count = 0;
    wr_count   = 0;
    rd_count   = 0;
    load_expect(src);
    pulse_dma(page);
  endtask

  task automatic wait_wr(input int n);
    int k = 0;
    while (wr_count < n && k < 1000) begin
      @(negedge clk); #1; k++;
    end
    check("reach_wr_count", 32'(wr_count >= n), 32'd1);
  endtask

  task automatic wait_rd(input int n);
    int k = 0;
    while (rd_count < n && k < 1000) begin
      @(negedge clk); #1; k++;
    end
    check("reach_rd_count", 32'(rd_count >= n), 32'd1);
  endtask

  task automatic finish_run(input int exp_cycles);
    int k = 0;
    while (!done && k < 2000) begin
      @(negedge clk); k++;
    end
    #1;
    check("done_seen", 32'(done), 32'd1);
    check("done_cycle", 32'(cyc - t0 + 1), 32'(exp_cycles));
    check("busy_with_done", 32'(busy), 32'd0);
    @(negedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    check("wr_count", 32'(wr_count), 32'd160);
    check("rd_left", 32'(exp_rd_q.size()), 32'd0);
    check("wr_left", 32'(exp_wr_q.size()), 32'd0);
    check("done_count", 32'(done_count), 32'd1);
    check("addr_hold", 32'(mem_addr), 32'h0000FE9F);
  endtask

  task automatic check_reset_outputs();
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hram", 32'(cpu_hram_only), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst      = 1'b1;
    dma_wr   = 1'b0;
    dma_page = 8'h00;
    bus_gnt  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Plain transfer from C100.
    begin_run(8'hC1, 8'hC1);
    finish_run(322);

    // Echo fold and the page just below the fold.
    begin_run(8'hF3, 8'hD3);
    finish_run(322);
    begin_run(8'hDF, 8'hDF);
    finish_run(322);

    // Grant stalls: 5 cycles in READ idx 10, 5 cycles in WRITE idx 20.
    begin_run(8'hC2, 8'hC2);
    wait_wr(10);
    @(posedge clk); #1 bus_gnt = 1'b0;
    repeat (5) @(posedge clk);
    #1 bus_gnt = 1'b1;
    wait_rd(21);
    @(posedge clk); #1 bus_gnt = 1'b0;
    repeat (5) @(posedge clk);
    #1 bus_gnt = 1'b1;
    finish_run(332);

    // Retrigger at idx 50 with page 80.
    begin_run(8'hC3, 8'hC3);
    wait_wr(50);
    @(negedge clk);
    dma_wr   = 1'b1;
    dma_page = 8'h80;
    @(negedge clk);
    dma_wr   = 1'b0;
    t0       = cyc;
    wr_count = 0;
    rd_count = 0;
    load_expect(8'h80);
    finish_run(322);

    // Reset in the middle of a transfer.
    begin_run(8'hC4, 8'hC4);
    wait_wr(77);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    exp_rd_q.delete();
    exp_wr_q.delete();
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("idle_after_rst", 32'(busy), 32'd0);
    check("no_done_after_rst", 32'(done_count), 32'd0);
    begin_run(8'h42, 8'h42);
    finish_run(322);

    // Retrigger on the final WRITE cycle: no done for the first run.
    begin_run(8'hC5, 8'hC5);
    wait_rd(160);
    @(negedge clk);
    dma_wr   = 1'b1;
    dma_page = 8'h11;
    @(negedge clk);
    dma_wr   = 1'b0;
    t0       = cyc;
    #1;
    check("no_done_on_retrig", 32'(done_count), 32'd0);
    check("busy_on_retrig", 32'(busy), 32'd1);
    wr_count = 0;
    rd_count = 0;
    load_expect(8'h11);
    finish_run(322);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
